// File: rtl/arbt_fifo.sv
`default_nettype none
// ============================================================================
// Module      : arbt_fifo
// Description : Circular FIFO placed downstream of the fixed-priority arbiter.
//               It acknowledges arbiter words while space remains and offers
//               them to the consumer over a valid/ready interface. Consumer
//               back-pressure never reaches the arbiter combinationally.
// Revision    : 1.0 - initial release
// ============================================================================
module arbt_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [DATA_WIDTH-1:0]   arbt_data_i,
    input  logic                    arbt_rdy_i,
    output logic                    arbt_ack_o,
    output logic [DATA_WIDTH-1:0]   data_o,
    output logic                    valid_o,
    input  logic                    ready_i,
    output logic [$clog2(DEPTH):0]  count_o,
    output logic                    full_o,
    output logic                    empty_o
);

    localparam int ADDR_WIDTH = $clog2(DEPTH);
    localparam int CNT_WIDTH  = ADDR_WIDTH + 1;
    localparam logic [CNT_WIDTH-1:0] PTR_ONE   = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] PTR_ZERO  = '0;
    localparam logic [CNT_WIDTH-1:0] DEPTH_CNT = CNT_WIDTH'(DEPTH);

    // Pointers carry one extra wrap bit so full and empty can be told apart.
    logic [CNT_WIDTH-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_WIDTH-1:0]  rd_ptr_q, rd_ptr_d;
    logic [DATA_WIDTH-1:0] mem_q [0:DEPTH-1];
    logic [DATA_WIDTH-1:0] mem_d [0:DEPTH-1];

    logic w_push;
    logic w_pop;

    // Status flags and handshakes come only from registered pointers plus
    // arbt_rdy_i; ready_i never feeds arbt_ack_o.
    always_comb begin
        empty_o    = (wr_ptr_q == rd_ptr_q);
        full_o     = (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]) &&
                     (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]);
        count_o    = wr_ptr_q - rd_ptr_q;
        valid_o    = ~empty_o;
        data_o     = mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];
        arbt_ack_o = arbt_rdy_i & ~full_o & ~rst_i;
        w_push     = arbt_ack_o;
        w_pop      = valid_o & ready_i;
    end

    // Next-state pointers: a push and a pop in the same cycle both advance.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (w_push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    // Next-state storage: only the slot under the write pointer changes.
    always_comb begin
        mem_d = mem_q;
        if (w_push) begin
            mem_d[wr_ptr_q[ADDR_WIDTH-1:0]] = arbt_data_i;
        end
    end

    // Pointer registers; reset discards contents by realigning the pointers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= PTR_ZERO;
            rd_ptr_q <= PTR_ZERO;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage registers are deliberately left without reset.
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

    // Structural sanity checks on the running FIFO.
    a_not_full_and_empty : assert property (@(posedge clk_i) disable iff (rst_i)
        !(full_o && empty_o))
        else $error("arbt_fifo: full and empty together");

    a_count_bound : assert property (@(posedge clk_i) disable iff (rst_i)
        count_o <= DEPTH_CNT)
        else $error("arbt_fifo: count exceeds depth");

    a_ack_needs_rdy : assert property (@(posedge clk_i)
        arbt_ack_o |-> arbt_rdy_i)
        else $error("arbt_fifo: ack without rdy");

    a_depth_legal : assert property (@(posedge clk_i)
        (DEPTH >= 2) && ((DEPTH & (DEPTH - 1)) == 0))
        else $error("arbt_fifo: DEPTH must be a power of two >= 2");

endmodule
`default_nettype wire
